cpu_fetch: RTL
==============

# cpu_fetch

Instruction fetch stage of the moxie core, directly upstream of the decode unit. It issues word reads to instruction memory, buffers returned data as big-endian halfwords, and assembles complete instructions: a 16-bit opcode plus, for long forms, a 32-bit operand. It presents each instruction to decode with a valid flag, honours the decode stall, and redirects on branches.

## Interface
- RESET_PC, 32'h0000_1000: first fetch address after reset; halfword aligned.
- QDEPTH, 8: halfword queue depth; power of two, ≥ 4.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_adr_o  out  32  word address of the read; bits [1:0] always 0.
- imem_stb_o  out  1  read request; held until imem_ack_i.
- imem_ack_i  in  1  read data valid this cycle; ends the request.
- imem_dat_i  in  32  read data; [31:16] is the lower-address halfword.
- branch_i  in  1  redirect request, single-cycle pulse.
- branch_target_i  in  32  redirect address; halfword aligned.
- stall_i  in  1  decode cannot accept; hold outputs.
- opcode_o  out  16  instruction opcode, to decode opcode_i.
- operand_o  out  32  immediate for long forms, else 0; to decode operand_i.
- valid_o  out  1  opcode_o/operand_o hold a real instruction; to decode valid_i.
- pc_o  out  32  address of the presented opcode.

## Operation
- Reset values: imem_stb_o=0, imem_adr_o=RESET_PC&~3, valid_o=0, opcode_o=0, operand_o=0, pc_o=RESET_PC, queue empty, discard flag=0, skip-first-halfword flag=RESET_PC[1].
- Request rule: one outstanding read at most. imem_stb_o rises when no request is outstanding and free slots minus 2 ≥ 0. The request holds adr and stb until ack. It is never withdrawn.
- On ack, if the discard flag is clear: push imem_dat_i[31:16], then [15:0]. If the skip flag is set, push only [15:0] and clear the flag. Fetch address += 4, wrapping modulo 2^32.
- Length: the opcode is long when opcode[15:8] ∈ {01,03,08,09,0C,0D,1A} (hex). Otherwise it is short.
- Issue: when stall_i=0, pop 1 halfword for a short opcode if count ≥ 1. Pop 3 halfwords for a long opcode if count ≥ 3; the operand is halfwords 2,3, big-endian. Register opcode_o, operand_o and pc_o, and set valid_o=1. pc advances by 2 or 6.
- When stall_i=0 and no complete instruction is available: valid_o=0; opcode_o and operand_o are unchanged.
- When stall_i=1: all outputs are held, with no pop.
- Branch:
  - Flush the queue and set valid_o=0 the next cycle.
  - Fetch address = target&~3; pc = target; skip flag = target[1].
  - If a request is outstanding and unacked, set the discard flag. The next ack is then dropped and the flag cleared.
  - Branch overrides stall_i.
- Simultaneous branch and ack: the ack data is dropped, no discard flag is set, and the new request may issue next cycle.
- Queue pointers wrap modulo QDEPTH. Count is clog2(QDEPTH)+1 bits. Full means count == QDEPTH; no push beyond it, which is guaranteed by the request rule.
- Push and pop in the same cycle are allowed. The issue decision uses pre-push count and contents.

## Timing
- Reset release at edge 0: imem_stb_o=1 after edge 1.
- Ack sampled at edge k: halfwords are queued at edge k. The earliest valid_o is after edge k+1 (one-cycle fetch-to-decode latency).
- Steady state with zero-wait memory: one short instruction per cycle, sustained with a 2-halfword-per-cycle fill. A long instruction needs 3 queued halfwords.
- Branch at edge b: valid_o=0 after edge b. The target request is issued after edge b+1 if none is outstanding. The first target instruction is valid at the earliest 2 cycles after the target ack.
- rst_i asserted mid-request: everything returns to reset values immediately. A late ack after reset is ignored because stb=0.

## Structure
- Shared package cpu_pkg holds:
  - width constants (OPCODE_W=16, WORD_W=32);
  - the long-opcode list and an is_long_opcode function, also used by decode.
- One sub-module: cpu_fetch_queue. It is a halfword FIFO parameterised by QDEPTH, with up to 2 pushes per cycle, up to 3 peeks/pops per cycle, a count output, and a flush.

## Test plan
- Reset, memory returns 0x9120_0000 at 0x1000 with zero-wait ack → valid_o with opcode 0x9120 (pc 0x1000), then 0x0000 (pc 0x1002) on consecutive cycles.
- Long form: words 0x0110_1234 and 0x5678_0000 → one instruction: opcode 0x0110, operand 0x1234_5678, pc 0x1000. The next pc is 0x1006.
- Stall held 5 cycles with the queue filling → outputs are constant. No request issues once count is 7 or 8. The instruction stream resumes without loss or duplication.
- Branch to 0x2002 while a read of 0x1008 is outstanding with a 3-cycle ack delay → the 0x1008 data is dropped and the next request is 0x2000. The first valid opcode is the low halfword, with pc_o 0x2002.
- Branch and ack in the same cycle → the ack data is never presented, and valid_o=0 the following cycle.
- rst_i pulsed mid-stream → all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the moxie core: data widths, instruction length decode
// and the fetch issue encoding.
package cpu_pkg;

  localparam int OPCODE_W   = 16;
  localparam int WORD_W     = 32;
  localparam int N_LONG_OPS = 7;

  typedef logic [OPCODE_W-1:0] hword_t;
  typedef logic [WORD_W-1:0]   word_t;

  // Major opcodes (opcode[15:8]) that carry a trailing 32-bit operand.
  localparam logic [7:0] LONG_OPS [N_LONG_OPS] = '{
    8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A
  };

  typedef enum logic [1:0] {
    ISSUE_NONE,
    ISSUE_SHORT,
    ISSUE_LONG
  } issue_e;

  function automatic logic is_long_opcode(input hword_t op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LONG_OPS; i++) begin
      if (op[15:8] == LONG_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and imem (slave).
interface cpu_fetch_if;
  import cpu_pkg::*;

  word_t imem_adr_o;
  logic  imem_stb_o;
  logic  imem_ack_i;
  word_t imem_dat_i;

  modport master (
    output imem_adr_o,
    output imem_stb_o,
    input  imem_ack_i,
    input  imem_dat_i
  );

  modport slave (
    input  imem_adr_o,
    input  imem_stb_o,
    output imem_ack_i,
    output imem_dat_i
  );

endinterface

// File: rtl/cpu_fetch_queue.sv
// Halfword FIFO for the fetch stage: up to two pushes and three pops per cycle,
// with three-entry lookahead so a long instruction can be taken in one cycle.
module cpu_fetch_queue
  import cpu_pkg::*;
#(
  parameter int  QDEPTH = 8,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  hword_t        push_d0,
  input  hword_t        push_d1,
  input  logic [1:0]    pop_cnt,
  output hword_t        peek0,
  output hword_t        peek1,
  output hword_t        peek2,
  output logic [CW-1:0] count
);

  hword_t        mem [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign peek0 = mem[rd_ptr];
  assign peek1 = mem[rd_ptr + PW'(1)];
  assign peek2 = mem[rd_ptr + PW'(2)];

  // Storage needs no reset: nothing is read until count says it was written.
  always_ff @(posedge clk_i) begin
    if (!flush) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= push_d0;
      if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= push_d1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      count  <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Moxie instruction fetch: word reads from imem, halfword buffering, and
// assembly of short/long instructions for decode, with stall and branch redirect.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_1000,
  parameter int    QDEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cpu_fetch_if.master imem,
  input  logic        branch_i,
  input  word_t       branch_target_i,
  input  logic        stall_i,
  output hword_t      opcode_o,
  output word_t       operand_o,
  output logic        valid_o,
  output word_t       pc_o
);

  localparam int CW = $clog2(QDEPTH) + 1;

  word_t         nxt_adr;
  word_t         pc_q;
  logic          discard_q;
  logic          skip_q;
  logic          ack_v;
  logic          take_data;
  logic          req_open;
  logic          req_new;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  hword_t        push_d0;
  hword_t        push_d1;
  hword_t        peek0;
  hword_t        peek1;
  hword_t        peek2;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_nxt;
  issue_e        issue;

  assign ack_v     = imem.imem_stb_o & imem.imem_ack_i;
  // Data arriving with a branch, or for a read issued before one, is stale.
  assign take_data = ack_v & ~discard_q & ~branch_i;

  always_comb begin
    push_cnt = 2'd0;
    push_d0  = imem.imem_dat_i[31:16];
    push_d1  = imem.imem_dat_i[15:0];
    if (take_data) begin
      if (skip_q) begin
        push_cnt = 2'd1;
        push_d0  = imem.imem_dat_i[15:0];
      end else begin
        push_cnt = 2'd2;
      end
    end
  end

  // Issue looks only at what was queued before this cycle's push.
  always_comb begin
    issue = ISSUE_NONE;
    if (!branch_i && !stall_i && q_count != '0) begin
      if (!is_long_opcode(peek0))    issue = ISSUE_SHORT;
      else if (q_count >= CW'(3))    issue = ISSUE_LONG;
    end
  end

  always_comb begin
    case (issue)
      ISSUE_SHORT: pop_cnt = 2'd1;
      ISSUE_LONG:  pop_cnt = 2'd3;
      default:     pop_cnt = 2'd0;
    endcase
  end

  assign count_nxt = branch_i ? '0 : q_count + CW'(push_cnt) - CW'(pop_cnt);
  assign req_open  = imem.imem_stb_o & ~imem.imem_ack_i;
  // A new read only starts when the whole returned word is sure to fit.
  assign req_new   = ~req_open & ~branch_i & (count_nxt <= CW'(QDEPTH - 2));

  cpu_fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (branch_i),
    .push_cnt (push_cnt),
    .push_d0  (push_d0),
    .push_d1  (push_d1),
    .pop_cnt  (pop_cnt),
    .peek0    (peek0),
    .peek1    (peek1),
    .peek2    (peek2),
    .count    (q_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imem.imem_stb_o <= 1'b0;
      imem.imem_adr_o <= {RESET_PC[31:2], 2'b00};
      nxt_adr         <= {RESET_PC[31:2], 2'b00};
      discard_q       <= 1'b0;
      skip_q          <= RESET_PC[1];
    end else begin
      imem.imem_stb_o <= req_open | req_new;
      if (req_new) begin
        imem.imem_adr_o <= nxt_adr;
        nxt_adr         <= nxt_adr + 32'd4;
      end
      if (branch_i) begin
        nxt_adr <= {branch_target_i[31:2], 2'b00};
        skip_q  <= branch_target_i[1];
      end else if (take_data) begin
        skip_q  <= 1'b0;
      end
      if (branch_i && req_open) discard_q <= 1'b1;
      else if (ack_v)           discard_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      opcode_o  <= '0;
      operand_o <= '0;
      pc_o      <= RESET_PC;
      pc_q      <= RESET_PC;
    end else if (branch_i) begin
      valid_o <= 1'b0;
      pc_q    <= branch_target_i;
    end else if (!stall_i) begin
      case (issue)
        ISSUE_SHORT: begin
          valid_o   <= 1'b1;
          opcode_o  <= peek0;
          operand_o <= '0;
          pc_o      <= pc_q;
          pc_q      <= pc_q + 32'd2;
        end
        ISSUE_LONG: begin
          valid_o   <= 1'b1;
          opcode_o  <= peek0;
          operand_o <= {peek1, peek2};
          pc_o      <= pc_q;
          pc_q      <= pc_q + 32'd6;
        end
        default: valid_o <= 1'b0;
      endcase
    end
  end

endmodule
